// File: rtl/csr_counter_unit.sv
// Machine-mode counter/timer CSR bank (mcycle, minstret, hpm3.., mcounteren) with user read-only shadows.
// Response registered one cycle after each request; a request is accepted every cycle, never stalls.
module csr_counter_unit #(
    parameter int XLEN      = 64,
    parameter int NB_EVENTS = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 csr_req_valid_i,
    input  logic [11:0]          csr_addr_i,
    input  logic [1:0]           csr_op_i,
    input  logic                 csr_we_i,
    input  logic [XLEN-1:0]      csr_wdata_i,
    input  logic [1:0]           priv_i,
    input  logic                 retire_i,
    input  logic [NB_EVENTS-1:0] event_i,
    output logic                 csr_rvalid_o,
    output logic [XLEN-1:0]      csr_rdata_o,
    output logic                 csr_illegal_o
);
    localparam logic [1:0] PRIV_M = 2'd3;
    localparam logic [1:0] OP_RS  = 2'b10;
    localparam logic [1:0] OP_RC  = 2'b11;

    logic [XLEN-1:0] mcycle;
    logic [XLEN-1:0] minstret;
    logic [XLEN-1:0] hpm [NB_EVENTS];
    logic [31:0]     mcounteren;

    logic [4:0]      idx;
    logic            in_m;
    logic            in_u;
    logic            in_cen;
    logic            legal;
    logic            do_wr;
    logic            wr_cnt;
    logic            wr_cen;
    logic [XLEN-1:0] cnt_val;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] wr_val;

    // 0xB00..0xB1F and 0xC00..0xC1F share the low five address bits as counter index.
    assign idx    = csr_addr_i[4:0];
    assign in_m   = (csr_addr_i[11:5] == 7'h58);
    assign in_u   = (csr_addr_i[11:5] == 7'h60);
    assign in_cen = (csr_addr_i == 12'h306);

    always_comb begin
        cnt_val = '0;
        if (idx == 5'd0 || (idx == 5'd1 && in_u)) begin
            cnt_val = mcycle;
        end else if (idx == 5'd2) begin
            cnt_val = minstret;
        end
        for (int k = 0; k < NB_EVENTS; k++) begin
            if (int'(idx) == k + 3) begin
                cnt_val = hpm[k];
            end
        end
    end

    always_comb begin
        legal = 1'b0;
        if (in_m || in_cen) begin
            legal = (priv_i == PRIV_M);
        end else if (in_u) begin
            legal = !csr_we_i && (priv_i == PRIV_M || mcounteren[idx]);
        end
    end

    assign old_val = in_cen ? {{(XLEN-32){1'b0}}, mcounteren} : cnt_val;

    always_comb begin
        case (csr_op_i)
            OP_RS:   wr_val = old_val | csr_wdata_i;
            OP_RC:   wr_val = old_val & ~csr_wdata_i;
            default: wr_val = csr_wdata_i;
        endcase
    end

    assign do_wr  = csr_req_valid_i && legal && csr_we_i && (csr_op_i != 2'b00);
    assign wr_cnt = do_wr && in_m;
    assign wr_cen = do_wr && in_cen;

    // A write in the same cycle replaces that cycle's increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcycle     <= '0;
            minstret   <= '0;
            mcounteren <= '0;
            for (int k = 0; k < NB_EVENTS; k++) begin
                hpm[k] <= '0;
            end
        end else begin
            mcycle   <= (wr_cnt && idx == 5'd0) ? wr_val : mcycle + XLEN'(1);
            minstret <= (wr_cnt && idx == 5'd2) ? wr_val : minstret + XLEN'(retire_i);
            for (int k = 0; k < NB_EVENTS; k++) begin
                if (wr_cnt && int'(idx) == k + 3) begin
                    hpm[k] <= wr_val;
                end else begin
                    hpm[k] <= hpm[k] + XLEN'(event_i[k]);
                end
            end
            if (wr_cen) begin
                mcounteren <= wr_val[31:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_rvalid_o  <= 1'b0;
            csr_rdata_o   <= '0;
            csr_illegal_o <= 1'b0;
        end else begin
            csr_rvalid_o <= csr_req_valid_i;
            if (csr_req_valid_i) begin
                csr_rdata_o   <= legal ? old_val : '0;
                csr_illegal_o <= !legal;
            end
        end
    end
endmodule

// File: tb/tb_csr_counter_unit.sv
// Bench for csr_counter_unit: directed steps then random accesses against an array-based counter model.
module tb_csr_counter_unit;
    localparam int XLEN = 64;
    localparam int NB   = 14;

    logic            clk     = 1'b0;
    logic            reset   = 1'b1;
    logic            req_vld = 1'b0;
    logic [11:0]     addr    = '0;
    logic [1:0]      op      = '0;
    logic            we      = 1'b0;
    logic [XLEN-1:0] wdata   = '0;
    logic [1:0]      priv    = 2'd3;
    logic            retire  = 1'b0;
    logic [NB-1:0]   ev      = '0;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            illegal;

    int total = 0;
    int bad   = 0;

    // Model: slot i holds the counter seen at 0xB00+i; only mapped slots ever change.
    logic [63:0] mdl [32];
    logic [31:0] mdl_cen;
    logic [63:0] exp_rdata;
    logic        exp_ill;
    logic [63:0] v0;

    logic [11:0] pool [19] = '{12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB05, 12'hB10, 12'hB11,
                               12'hB1F, 12'hC00, 12'hC01, 12'hC02, 12'hC03, 12'hC10, 12'hC1F,
                               12'h306, 12'h300, 12'hA00, 12'hB20, 12'hC20};

    csr_counter_unit #(.XLEN(XLEN), .NB_EVENTS(NB)) dut (
        .clk             (clk),
        .reset           (reset),
        .csr_req_valid_i (req_vld),
        .csr_addr_i      (addr),
        .csr_op_i        (op),
        .csr_we_i        (we),
        .csr_wdata_i     (wdata),
        .priv_i          (priv),
        .retire_i        (retire),
        .event_i         (ev),
        .csr_rvalid_o    (rvalid),
        .csr_rdata_o     (rdata),
        .csr_illegal_o   (illegal)
    );

    always #5 clk = ~clk;

    function automatic bit is_real(input int i);
        return (i == 0) || (i == 2) || (i >= 3 && i < 3 + NB);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        mdl_cen = '0;
    endtask

    task automatic cycle(input string tag);
        logic        exp_vld;
        bit          in_m, in_u, in_cen, legal, wr;
        int          i;
        logic [63:0] old, nv;
        exp_vld = req_vld;
        in_m    = (addr >= 12'hB00) && (addr <= 12'hB1F);
        in_u    = (addr >= 12'hC00) && (addr <= 12'hC1F);
        in_cen  = (addr == 12'h306);
        i       = int'(addr) % 32;
        legal   = 1'b0;
        if (in_m || in_cen) legal = (priv == 2'd3);
        else if (in_u) legal = !we && (priv == 2'd3 || mdl_cen[i]);
        if (in_cen) old = {32'h0, mdl_cen};
        else if ((in_m || in_u) && i == 1) old = in_u ? mdl[0] : 64'h0;
        else if ((in_m || in_u) && is_real(i)) old = mdl[i];
        else old = 64'h0;
        wr = req_vld && legal && we && (op != 2'b00) && (in_cen || (in_m && is_real(i)));
        case (op)
            2'b10:   nv = old | wdata;
            2'b11:   nv = old & ~wdata;
            default: nv = wdata;
        endcase
        if (req_vld) begin
            exp_rdata = legal ? old : 64'h0;
            exp_ill   = !legal;
        end
        for (int j = 0; j < 32; j++) begin
            if (is_real(j)) begin
                if (wr && !in_cen && j == i) mdl[j] = nv;
                else if (j == 0) mdl[j] = mdl[j] + 64'd1;
                else if (j == 2) mdl[j] = mdl[j] + 64'(retire);
                else mdl[j] = mdl[j] + 64'(ev[j-3]);
            end
        end
        if (wr && in_cen) mdl_cen = nv[31:0];
        @(posedge clk);
        #1;
        chk({tag, ".rvalid"}, 64'(rvalid), 64'(exp_vld));
        if (exp_vld) begin
            chk({tag, ".rdata"}, rdata, exp_rdata);
            chk({tag, ".illegal"}, 64'(illegal), 64'(exp_ill));
        end
    endtask

    task automatic req(input logic [11:0] a, input logic [1:0] o, input logic w,
                       input logic [63:0] d, input logic [1:0] p, input string tag);
        req_vld = 1'b1;
        addr    = a;
        op      = o;
        we      = w;
        wdata   = d;
        priv    = p;
        cycle(tag);
        req_vld = 1'b0;
        we      = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rvalid", 64'(rvalid), 64'h0);
        chk("rst.rdata", rdata, 64'h0);
        chk("rst.illegal", 64'(illegal), 64'h0);
        reset = 1'b0;

        repeat (10) cycle("idle");
        req(12'hB00, 2'b00, 1'b0, 64'h0, 2'd3, "rd_mcycle");
        chk("mcycle_is_10", rdata, 64'd10);

        retire = 1'b1;
        req(12'hB02, 2'b01, 1'b1, 64'h100, 2'd3, "wr_minstret");
        chk("minstret_old", rdata, 64'd0);
        retire = 1'b0;
        req(12'hB02, 2'b00, 1'b0, 64'h0, 2'd3, "rd_minstret");
        chk("minstret_written", rdata, 64'h100);

        req(12'hB03, 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, "wr_hpm3");
        ev = 14'h1;
        repeat (2) cycle("ev_pulse");
        ev = '0;
        req(12'hB03, 2'b00, 1'b0, 64'h0, 2'd3, "rd_hpm3");
        chk("hpm3_wrap", rdata, 64'd1);

        req(12'hC02, 2'b00, 1'b0, 64'h0, 2'd0, "u_c02_denied");
        chk("u_c02_illegal", 64'(illegal), 64'd1);
        chk("u_c02_rdata0", rdata, 64'd0);
        req(12'h306, 2'b10, 1'b1, 64'h4, 2'd3, "rs_cen");
        req(12'hC02, 2'b00, 1'b0, 64'h0, 2'd0, "u_c02_ok");
        chk("u_c02_minstret", rdata, 64'h100);
        chk("u_c02_legal", 64'(illegal), 64'd0);

        req(12'hB00, 2'b00, 1'b0, 64'h0, 2'd3, "rd_mcycle_a");
        v0 = exp_rdata;
        req(12'hB00, 2'b01, 1'b1, 64'h0, 2'd0, "u_wr_b00");
        chk("u_wr_b00_illegal", 64'(illegal), 64'd1);
        req(12'hC00, 2'b01, 1'b1, 64'h0, 2'd3, "m_wr_c00");
        chk("m_wr_c00_illegal", 64'(illegal), 64'd1);
        req(12'hB00, 2'b00, 1'b0, 64'h0, 2'd3, "rd_mcycle_b");
        chk("mcycle_untouched", rdata, v0 + 64'd3);

        req(12'h306, 2'b10, 1'b1, 64'h1, 2'd3, "rs_cen1");
        req(12'h306, 2'b11, 1'b1, 64'h4, 2'd3, "rc_cen");
        chk("rc_cen_old", rdata, 64'h5);
        req(12'h306, 2'b00, 1'b0, 64'h0, 2'd3, "rd_cen");
        chk("cen_after_rc", rdata, 64'h1);
        req(12'h306, 2'b01, 1'b1, 64'hABCD_0000_0000_0002, 2'd3, "wr_cen_wide");
        req(12'h306, 2'b00, 1'b0, 64'h0, 2'd3, "rd_cen_wide");
        chk("cen_upper_dropped", rdata, 64'h2);

        retire = 1'b1;
        ev     = '1;
        req(12'hB02, 2'b00, 1'b0, 64'h0, 2'd3, "pre_rst");
        reset = 1'b1;
        #1;
        chk("midrst.rvalid", 64'(rvalid), 64'h0);
        retire = 1'b0;
        ev     = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        req(12'hB00, 2'b00, 1'b0, 64'h0, 2'd3, "post_rst_mcycle");
        chk("post_rst_mcycle0", rdata, 64'h0);
        req(12'hB02, 2'b00, 1'b0, 64'h0, 2'd3, "post_rst_minstret");
        chk("post_rst_minstret0", rdata, 64'h0);
        req(12'hB10, 2'b00, 1'b0, 64'h0, 2'd3, "post_rst_hpm16");
        chk("post_rst_hpm16_0", rdata, 64'h0);
        req(12'h306, 2'b00, 1'b0, 64'h0, 2'd3, "post_rst_cen");
        chk("post_rst_cen0", rdata, 64'h0);

        repeat (400) begin
            req_vld = ($urandom_range(0, 3) != 0);
            addr    = pool[$urandom_range(0, 18)];
            op      = 2'($urandom);
            we      = 1'($urandom);
            wdata   = {$urandom, $urandom};
            priv    = 2'($urandom);
            retire  = 1'($urandom);
            ev      = NB'($urandom);
            cycle("rnd");
        end
        req_vld = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
